// File: rtl/sram_arb_2048x39.sv
// Round-robin arbiter and sequencer for one single-port 2048x39 RAM macro.
// It clears the array after reset, then shares the macro between requesters A and B.
module sram_arb_2048x39 #(
    parameter int              BITS       = 39,
    parameter int              WORD_DEPTH = 2048,
    parameter int              ADDR_WIDTH = 11,
    parameter logic [BITS-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done_o,
    input  logic                  a_req_i,
    input  logic                  a_we_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [BITS-1:0]       a_wdata_i,
    input  logic [BITS-1:0]       a_wmask_i,
    output logic                  a_gnt_o,
    output logic                  a_rvalid_o,
    output logic [BITS-1:0]       a_rdata_o,
    input  logic                  b_req_i,
    input  logic                  b_we_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [BITS-1:0]       b_wdata_i,
    input  logic [BITS-1:0]       b_wmask_i,
    output logic                  b_gnt_o,
    output logic                  b_rvalid_o,
    output logic [BITS-1:0]       b_rdata_o,
    output logic                  ram_ce_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [BITS-1:0]       ram_wd_o,
    output logic [BITS-1:0]       ram_wmask_o,
    input  logic [BITS-1:0]       ram_rd_i
);

    if (ADDR_WIDTH != $clog2(WORD_DEPTH)) begin : g_bad_addr_width
        $error("ADDR_WIDTH must equal log2(WORD_DEPTH)");
    end

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;
    logic                  init_done_q;
    logic                  last_b_q;
    logic                  a_rv_q;
    logic                  b_rv_q;
    logic                  run;
    logic                  a_gnt;
    logic                  b_gnt;

    // Handshake: a requester holds req and its fields stable until the cycle gnt is
    // high; that cycle completes the access, and a read returns rvalid the next cycle.
    assign run   = (state_q == ST_RUN) && !rst;
    assign a_gnt = run && a_req_i && (!b_req_i || last_b_q);
    assign b_gnt = run && b_req_i && !a_gnt;
    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            last_b_q    <= 1'b1;
            a_rv_q      <= 1'b0;
            b_rv_q      <= 1'b0;
        end else begin
            a_rv_q <= a_gnt && !a_we_i;
            b_rv_q <= b_gnt && !b_we_i;
            if (a_gnt) begin
                last_b_q <= 1'b0;
            end else if (b_gnt) begin
                last_b_q <= 1'b1;
            end
            if (state_q == ST_INIT) begin
                cnt_q <= cnt_d;
                if (cnt_q == ADDR_WIDTH'(WORD_DEPTH - 1)) begin
                    state_q     <= ST_RUN;
                    init_done_q <= 1'b1;
                end
            end
        end
    end

    // The macro inputs are fully defined whenever ce is high; idle cycles drive zeros.
    always_comb begin
        ram_ce_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wd_o    = '0;
        ram_wmask_o = '0;
        if (!rst) begin
            if (state_q == ST_INIT) begin
                ram_ce_o    = 1'b1;
                ram_we_o    = 1'b1;
                ram_addr_o  = cnt_q;
                ram_wd_o    = INIT_VALUE;
                ram_wmask_o = '1;
            end else if (a_gnt) begin
                ram_ce_o    = 1'b1;
                ram_we_o    = a_we_i;
                ram_addr_o  = a_addr_i;
                ram_wd_o    = a_wdata_i;
                ram_wmask_o = a_wmask_i;
            end else if (b_gnt) begin
                ram_ce_o    = 1'b1;
                ram_we_o    = b_we_i;
                ram_addr_o  = b_addr_i;
                ram_wd_o    = b_wdata_i;
                ram_wmask_o = b_wmask_i;
            end
        end
    end

    assign init_done_o = init_done_q;
    assign a_gnt_o     = a_gnt;
    assign b_gnt_o     = b_gnt;
    assign a_rvalid_o  = a_rv_q;
    assign b_rvalid_o  = b_rv_q;
    assign a_rdata_o   = a_rv_q ? ram_rd_i : '0;
    assign b_rdata_o   = b_rv_q ? ram_rd_i : '0;

endmodule

// File: tb/tb_sram_arb_2048x39.sv
// Bench for sram_arb_2048x39: directed vector table, randomized traffic against a
// shadow-memory reference, init sweep and reset-during-read sequences.
module tb_sram_arb_2048x39;

    localparam int BITS  = 39;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;
    localparam logic [BITS-1:0] ONES = '1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            init_done;
    logic            a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0]   a_addr = '0;
    logic [BITS-1:0] a_wd = '0, a_wm = '0;
    logic            a_gnt, a_rv;
    logic [BITS-1:0] a_rd;
    logic            b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0]   b_addr = '0;
    logic [BITS-1:0] b_wd = '0, b_wm = '0;
    logic            b_gnt, b_rv;
    logic [BITS-1:0] b_rd;
    logic            ram_ce, ram_we;
    logic [AW-1:0]   ram_addr;
    logic [BITS-1:0] ram_wd, ram_wm;
    logic [BITS-1:0] ram_rd = '0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sram_arb_2048x39 dut (
        .clk(clk), .rst(rst), .init_done_o(init_done),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wd), .a_wmask_i(a_wm),
        .a_gnt_o(a_gnt), .a_rvalid_o(a_rv), .a_rdata_o(a_rd),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wd), .b_wmask_i(b_wm),
        .b_gnt_o(b_gnt), .b_rvalid_o(b_rv), .b_rdata_o(b_rd),
        .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wd_o(ram_wd),
        .ram_wmask_o(ram_wm), .ram_rd_i(ram_rd)
    );

    // Behavioural fakeram45 macro: registered read, per-bit masked write, garbage at power-up.
    logic [BITS-1:0] mem [DEPTH];
    bit filled = 1'b0;
    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= BITS'({$urandom(), $urandom()});
            filled <= 1'b1;
        end else if (ram_ce) begin
            if (ram_we) mem[ram_addr] <= (ram_wd & ram_wm) | (mem[ram_addr] & ~ram_wm);
            else        ram_rd <= mem[ram_addr];
        end
    end

    // Reference model: expected memory contents, who was served last, queued read returns.
    logic [BITS-1:0] ref_mem [DEPTH];
    bit              m_last_b;
    bit              a_exp_v, b_exp_v;
    logic [BITS-1:0] a_exp_q[$];
    logic [BITS-1:0] b_exp_q[$];
    logic            obs_ag, obs_bg, obs_arv, obs_brv;
    logic [BITS-1:0] obs_ard, obs_brd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        m_last_b = 1'b1;
        a_exp_v  = 1'b0;
        b_exp_v  = 1'b0;
        a_exp_q.delete();
        b_exp_q.delete();
    endtask

    // Called just after a posedge with inputs already driven; checks at negedge.
    task automatic step();
        bit eag, ebg;
        @(negedge clk);
        eag = a_req && (!b_req || m_last_b);
        ebg = b_req && !eag;
        obs_ag = a_gnt; obs_bg = b_gnt; obs_arv = a_rv; obs_brv = b_rv;
        obs_ard = a_rd; obs_brd = b_rd;
        chk("a_gnt", 64'(a_gnt), 64'(eag));
        chk("b_gnt", 64'(b_gnt), 64'(ebg));
        chk("ram_ce", 64'(ram_ce), 64'(eag | ebg));
        if (eag || ebg) begin
            chk("ram_we", 64'(ram_we), 64'(eag ? a_we : b_we));
            chk("ram_addr", 64'(ram_addr), 64'(eag ? a_addr : b_addr));
            if (eag ? a_we : b_we) begin
                chk("ram_wd", 64'(ram_wd), 64'(eag ? a_wd : b_wd));
                chk("ram_wmask", 64'(ram_wm), 64'(eag ? a_wm : b_wm));
            end
        end else begin
            chk("ram_we_idle", 64'(ram_we), 64'(0));
        end
        chk("a_rvalid", 64'(a_rv), 64'(a_exp_v));
        chk("a_rdata", 64'(a_rd), a_exp_v ? 64'(a_exp_q.pop_front()) : 64'(0));
        chk("b_rvalid", 64'(b_rv), 64'(b_exp_v));
        chk("b_rdata", 64'(b_rd), b_exp_v ? 64'(b_exp_q.pop_front()) : 64'(0));
        a_exp_v = eag && !a_we;
        b_exp_v = ebg && !b_we;
        if (a_exp_v) a_exp_q.push_back(ref_mem[a_addr]);
        if (b_exp_v) b_exp_q.push_back(ref_mem[b_addr]);
        if (eag && a_we) ref_mem[a_addr] = (a_wd & a_wm) | (ref_mem[a_addr] & ~a_wm);
        if (ebg && b_we) ref_mem[b_addr] = (b_wd & b_wm) | (ref_mem[b_addr] & ~b_wm);
        if (eag) m_last_b = 1'b0;
        if (ebg) m_last_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Full clearing sweep with both requesters knocking; nothing may be granted.
    task automatic sweep_check();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("sweep_addr", 64'(ram_addr), 64'(i));
            chk("sweep_ce", 64'(ram_ce), 64'(1));
            chk("sweep_we", 64'(ram_we), 64'(1));
            chk("sweep_wd", 64'(ram_wd), 64'(0));
            chk("sweep_wmask", 64'(ram_wm), 64'(ONES));
            chk("sweep_gnt", 64'({a_gnt, b_gnt}), 64'(0));
            chk("sweep_rvalid", 64'({a_rv, b_rv}), 64'(0));
            chk("sweep_init_done", 64'(init_done), 64'(0));
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic a_req, a_we; logic [AW-1:0] a_addr; logic [BITS-1:0] a_wd, a_wm;
        logic b_req, b_we; logic [AW-1:0] b_addr; logic [BITS-1:0] b_wd, b_wm;
        logic eag, ebg, earv; logic [BITS-1:0] eard; logic ebrv; logic [BITS-1:0] ebrd;
    } vec_t;

    function automatic vec_t mk(
        logic ar, logic aw, int aad, logic [BITS-1:0] awd, logic [BITS-1:0] awm,
        logic br, logic bw, int bad, logic [BITS-1:0] bwd, logic [BITS-1:0] bwm,
        logic eag, logic ebg, logic earv, logic [BITS-1:0] eard, logic ebrv, logic [BITS-1:0] ebrd);
        vec_t v;
        v.a_req = ar; v.a_we = aw; v.a_addr = AW'(aad); v.a_wd = awd; v.a_wm = awm;
        v.b_req = br; v.b_we = bw; v.b_addr = AW'(bad); v.b_wd = bwd; v.b_wm = bwm;
        v.eag = eag; v.ebg = ebg; v.earv = earv; v.eard = eard; v.ebrv = ebrv; v.ebrd = ebrd;
        return v;
    endfunction

    vec_t vecs [12];
    bit a_hold, b_hold;

    initial begin
        vecs[0]  = mk(1,1,'h155,39'h7F_FFFF_FFFF,39'h00_0000_FFFF, 0,0,0,0,0,       1,0, 0,0, 0,0);
        vecs[1]  = mk(1,0,'h155,0,0,                               0,0,0,0,0,       1,0, 0,0, 0,0);
        vecs[2]  = mk(0,0,0,0,0,                                   0,0,0,0,0,       0,0, 1,39'hFFFF, 0,0);
        vecs[3]  = mk(0,0,0,0,0, 1,1,7,39'h12_3456_789A,ONES,                        0,1, 0,0, 0,0);
        vecs[4]  = mk(1,0,7,0,0,                                   0,0,0,0,0,       1,0, 0,0, 0,0);
        vecs[5]  = mk(0,0,0,0,0,                                   0,0,0,0,0,       0,0, 1,39'h12_3456_789A, 0,0);
        vecs[6]  = mk(1,0,'h155,0,0,                               1,0,7,0,0,       0,1, 0,0, 0,0);
        vecs[7]  = mk(1,0,'h155,0,0,                               1,0,0,0,0,       1,0, 0,0, 1,39'h12_3456_789A);
        vecs[8]  = mk(1,0,1023,0,0,                                1,0,0,0,0,       0,1, 1,39'hFFFF, 0,0);
        vecs[9]  = mk(1,0,1023,0,0,                                1,0,2047,0,0,    1,0, 0,0, 1,0);
        vecs[10] = mk(1,0,'h155,0,0,                               1,0,2047,0,0,    0,1, 1,0, 0,0);
        vecs[11] = mk(0,0,0,0,0,                                   0,0,0,0,0,       0,0, 0,0, 1,0);

        // Reset: two cycles held, both requesters already asking.
        model_reset();
        rst = 1'b1; a_req = 1'b1; b_req = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ce", 64'(ram_ce), 64'(0));
        chk("rst_gnt", 64'({a_gnt, b_gnt}), 64'(0));
        @(posedge clk); #1;
        chk("rst_init_done", 64'(init_done), 64'(0));
        chk("rst_rvalid", 64'({a_rv, b_rv}), 64'(0));
        chk("rst_rdata", 64'(a_rd | b_rd), 64'(0));
        rst = 1'b0;
        sweep_check();
        a_req = 1'b0; b_req = 1'b0;
        step();
        chk("init_done_rise", 64'(init_done), 64'(1));

        // Directed vectors: masked write, write-then-read, round-robin, boundary reads.
        for (int i = 0; i < 12; i++) begin
            a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr;
            a_wd = vecs[i].a_wd; a_wm = vecs[i].a_wm;
            b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_addr = vecs[i].b_addr;
            b_wd = vecs[i].b_wd; b_wm = vecs[i].b_wm;
            step();
            chk($sformatf("vec%0d_a_gnt", i), 64'(obs_ag), 64'(vecs[i].eag));
            chk($sformatf("vec%0d_b_gnt", i), 64'(obs_bg), 64'(vecs[i].ebg));
            chk($sformatf("vec%0d_a_rv", i), 64'(obs_arv), 64'(vecs[i].earv));
            chk($sformatf("vec%0d_a_rd", i), 64'(obs_ard), 64'(vecs[i].eard));
            chk($sformatf("vec%0d_b_rv", i), 64'(obs_brv), 64'(vecs[i].ebrv));
            chk($sformatf("vec%0d_b_rd", i), 64'(obs_brd), 64'(vecs[i].ebrd));
        end

        // Idle stretch: no ce, no rvalid, zero read data.
        a_req = 1'b0; b_req = 1'b0;
        repeat (10) step();

        // Random traffic; fields held while a request waits for its grant.
        a_hold = 1'b0; b_hold = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (!a_hold) begin
                a_req  = ($urandom_range(0, 3) != 0);
                a_we   = 1'($urandom_range(0, 1));
                a_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                                     : AW'($urandom_range(0, 15));
                a_wd   = BITS'({$urandom(), $urandom()});
                a_wm   = BITS'({$urandom(), $urandom()});
            end
            if (!b_hold) begin
                b_req  = ($urandom_range(0, 3) != 0);
                b_we   = 1'($urandom_range(0, 1));
                b_addr = AW'($urandom_range(0, 15));
                b_wd   = BITS'({$urandom(), $urandom()});
                b_wm   = BITS'({$urandom(), $urandom()});
            end
            step();
            a_hold = a_req && !obs_ag;
            b_hold = b_req && !obs_bg;
        end

        // Reset in the same cycle as an A read: no rvalid after, sweep restarts from 0.
        a_req = 1'b1; a_we = 1'b0; a_addr = AW'(5); b_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = AW'(9);
        model_reset();
        sweep_check();
        a_req = 1'b0; b_req = 1'b0;
        step();
        chk("rerun_init_done", 64'(init_done), 64'(1));

        // After reset A wins the first tie again; earlier writes are wiped.
        a_req = 1'b1; a_we = 1'b0; a_addr = AW'('h155);
        b_req = 1'b1; b_we = 1'b0; b_addr = AW'(7);
        step();
        chk("post_rst_tie_a", 64'(obs_ag), 64'(1));
        a_req = 1'b0;
        step();
        chk("post_rst_b_gnt", 64'(obs_bg), 64'(1));
        chk("post_rst_cleared_155", 64'(obs_ard), 64'(0));
        b_req = 1'b0;
        step();
        chk("post_rst_cleared_7", 64'(obs_brd), 64'(0));
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arb_2048x39.md
Name: sram_arb_2048x39

Overview:
Two-requester arbiter and sequencer for a single-port 2048x39 fakeram45 macro with a 1-cycle registered read and per-bit write mask. After reset it clears the whole array with a walking-address write sweep. It then shares the macro between requesters A and B with a round-robin arbiter, and routes each read return to the requester that issued it. It sits between the pipeline clients and the RAM macro and is the only driver of the macro's ce/we/addr/wd/mask inputs.

Parameters:
BITS, 39, data and mask width
WORD_DEPTH, 2048, number of RAM words
ADDR_WIDTH, 11, address width; must equal log2(WORD_DEPTH)
INIT_VALUE, 0, BITS-wide word written to every address during the init sweep

Ports:
clk  in  1  single clock for the block and the RAM macro
rst  in  1  synchronous, active-high reset
init_done_o  out  1  high once the init sweep has completed
a_req_i  in  1  requester A access request
a_we_i  in  1  A: 1 = write, 0 = read
a_addr_i  in  ADDR_WIDTH  A address
a_wdata_i  in  BITS  A write data
a_wmask_i  in  BITS  A per-bit write enable
a_gnt_o  out  1  A accepted this cycle
a_rvalid_o  out  1  A read data valid
a_rdata_o  out  BITS  A read data
b_*  (same seven ports as a_*)  requester B
ram_ce_o  out  1  macro chip enable
ram_we_o  out  1  macro write enable
ram_addr_o  out  ADDR_WIDTH  macro address
ram_wd_o  out  BITS  macro write data
ram_wmask_o  out  BITS  macro write mask
ram_rd_i  in  BITS  macro rd_out

Behaviour:
- One clock domain, clk. Reset rst is synchronous and active-high; all state updates on posedge clk.
- FSM states:
  - INIT: entered on rst.
  - RUN: entered the cycle after the last init write.
  - No other states. Only rst returns the FSM to INIT.
- Reset values (the cycle after rst is sampled high):
  - state = INIT, init counter = 0, init_done_o = 0
  - a_rvalid_o = b_rvalid_o = 0
  - last-grant register = B, so A wins the first tie
  - a_gnt_o = b_gnt_o = 0
  - While rst is high, ram_ce_o = 0 combinationally.
- INIT (rst low):
  - Each cycle drives ram_ce_o=1, ram_we_o=1, ram_addr_o=counter, ram_wd_o=INIT_VALUE, ram_wmask_o=all ones.
  - Counter increments 0..WORD_DEPTH-1, so the sweep takes exactly WORD_DEPTH cycles.
  - After the write at address WORD_DEPTH-1, move to RUN and register init_done_o=1.
  - Both gnt outputs stay 0; requests are ignored and not queued.
- RUN arbitration (combinational grant):
  - Only A requesting: grant A.
  - Only B requesting: grant B.
  - Both requesting: grant the requester that was not granted most recently.
  - The last-grant register updates only on a grant.
  - At most one gnt is high per cycle; gnt is never high without its req.
- RUN RAM drive:
  - With a grant: ram_ce_o=1 and ram_we_o/ram_addr_o/ram_wd_o/ram_wmask_o are taken from the granted requester that cycle.
  - No grant: ram_ce_o=0, ram_we_o=0, and the other RAM outputs are don't-care (drive 0).
- Request protocol:
  - Requester fields must be stable while req is high.
  - A request completes in the cycle gnt is high. The requester may change fields or drop req the next cycle.
- Read return:
  - For a granted read in cycle N, x_rvalid_o=1 in cycle N+1 only, with x_rdata_o = ram_rd_i (combinational pass-through).
  - When x_rvalid_o=0, x_rdata_o is driven to 0, never X.
  - Granted writes produce no rvalid.
  - Back-to-back reads by the same requester give rvalid on consecutive cycles.
- Ordering:
  - Accesses reach the RAM strictly in grant order.
  - A read granted the cycle after a write to the same address returns the newly masked-in data.
- Masked write: new word = (wdata & wmask) | (old & ~wmask). The macro performs this; the block passes the mask unmodified.
- Reset mid-operation:
  - rst in INIT restarts the sweep at address 0.
  - rst in RUN drops a pending rvalid (no rvalid the following cycle), clears init_done_o, and reruns the full sweep.
- The block never drives ram_ce_o=1 with an X on ram_we_o or ram_addr_o, because an X there corrupts the macro.

Test Plan:
1. Sweep and init: assert rst 2 cycles, release -> init_done_o rises exactly 2048 cycles later; reads of addresses 0, 1023 and 2047 return 0; no gnt during the sweep even with a_req_i=b_req_i=1.
2. Masked write: A writes addr 0x155 with wdata 0x7F_FFFF_FFFF and wmask 0x00_0000_FFFF, then reads it -> a_rvalid_o one cycle after gnt with a_rdata_o=0x00_0000_FFFF.
3. Round-robin: A and B request continuously from init_done -> grants A,B,A,B...; each requester's reads return rvalid only on its own port, each one cycle after its own gnt.
4. Write-then-read same address: B writes addr 7 = 0x12_3456_789A (full mask) in cycle N, A reads addr 7 in cycle N+1 -> a_rdata_o=0x12_3456_789A in cycle N+2.
5. Idle: no requests for 10 cycles -> ram_ce_o=0 throughout; no rvalid; rdata outputs 0.
6. Reset mid-read: A read granted in cycle N, rst high in cycle N -> a_rvalid_o=0 in cycle N+1, init_done_o=0, and the sweep restarts at address 0.
